mem_arbiter: RTL and testbench

Shares one single-port unified memory between the pipeline's instruction-fetch (IF) and data-memory (DM) stages of the pipelined RISC-V CPU. Each cycle it decides which requester owns the memory port and routes the response back to that requester. Only one transaction is outstanding at a time. DM has priority, bounded by an anti-starvation rule for IF. It also keeps wait-cycle counters alongside the CPU's cycle and instruction counters.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the three buses around the memory arbiter:
//     IF  side : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//     DM  side : dm_req/dm_we/dm_wstrb/dm_addr/dm_wdata in,
//                dm_gnt/dm_rvalid/dm_rdata out
//     MEM side : mem_req/mem_we/mem_wstrb/mem_addr/mem_wdata out,
//                mem_rvalid/mem_rdata in
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus memory).
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between instruction fetch (IF) and data
//   memory (DM). One transaction outstanding at a time; DM has priority unless
//   IF has been passed over STARVE_MAX times in a row. Also counts requester
//   wait cycles and flags responses that arrive with nothing outstanding.
//
//   Ports:
//     clk        rising-edge clock
//     n_rst      asynchronous active-low reset
//     bus        mem_arbiter_if.slave (IF, DM and memory buses)
//     n_if_wait  cycles with if_req=1 and if_gnt=0, saturating
//     n_dm_wait  cycles with dm_req=1 and dm_gnt=0, saturating
//     err        sticky: mem_rvalid seen while no transaction outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4  // 1..15
) (
  input  logic         clk,
  input  logic         n_rst,
  mem_arbiter_if.slave bus,
  output logic [31:0]  n_if_wait,
  output logic [31:0]  n_dm_wait,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,  // waiting for mem_rvalid
    RESP = 2'd2   // delivering the response, may grant the next request
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q;
  logic        store_q;
  logic [31:0] rdata_q;
  logic [3:0]  starve_q;
  logic [31:0] if_wait_q;
  logic [31:0] dm_wait_q;
  logic        err_q;

  logic        can_grant;
  logic        if_win;
  logic        dm_win;

  // Arbitration is purely combinational from the requests. Gating with n_rst
  // keeps the zero-latency grant path silent while reset is held.
  always_comb begin
    can_grant = n_rst && (state_q != BUSY);
    if_win    = can_grant && bus.if_req &&
                (!bus.dm_req || (starve_q == 4'(STARVE_MAX)));
    dm_win    = can_grant && bus.dm_req && !if_win;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    bus.if_gnt    = if_win;
    bus.dm_gnt    = dm_win;
    bus.mem_req   = if_win || dm_win;
    bus.mem_we    = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (dm_win) begin
      bus.mem_we    = bus.dm_we;
      bus.mem_wstrb = bus.dm_wstrb;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end else if (if_win) begin
      bus.mem_addr  = bus.if_addr;
    end

    // Response data is visible only during the owner's rvalid pulse.
    bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    bus.dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);
    bus.if_rdata  = bus.if_rvalid ? rdata_q : 32'h0;
    bus.dm_rdata  = bus.dm_rvalid ? rdata_q : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP: state_d = (if_win || dm_win) ? BUSY : IDLE;
      BUSY:       if (bus.mem_rvalid) state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values present before the edge, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      store_q   <= 1'b0;
      rdata_q   <= 32'h0;
      starve_q  <= 4'h0;
      if_wait_q <= 32'h0;
      dm_wait_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (if_win) begin
        owner_q  <= OWN_IF;
        store_q  <= 1'b0;
        starve_q <= 4'h0;
      end else if (dm_win) begin
        owner_q  <= OWN_DM;
        store_q  <= bus.dm_we;
        // Only DM grants that pass over a waiting IF move IF towards its turn.
        starve_q <= bus.if_req ? starve_q + 4'h1 : 4'h0;
      end

      if ((state_q == BUSY) && bus.mem_rvalid) begin
        rdata_q <= store_q ? 32'h0 : bus.mem_rdata;
      end

      // A response with nothing outstanding is dropped; only the flag records it.
      if ((state_q != BUSY) && bus.mem_rvalid) begin
        err_q <= 1'b1;
      end

      if (bus.if_req && !if_win && (if_wait_q != 32'hFFFF_FFFF)) begin
        if_wait_q <= if_wait_q + 32'h1;
      end
      if (bus.dm_req && !dm_win && (dm_wait_q != 32'hFFFF_FFFF)) begin
        dm_wait_q <= dm_wait_q + 32'h1;
      end
    end
  end

  assign n_if_wait = if_wait_q;
  assign n_dm_wait = dm_wait_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed cases for the documented scenarios, then randomized traffic
//   against a cycle-arithmetic reference model. Expected responses are queued
//   at grant time and consumed by an independent monitor on rvalid.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] n_if_wait;
  logic [31:0] n_dm_wait;
  logic        err;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .n_if_wait (n_if_wait),
    .n_dm_wait (n_dm_wait),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t if_q[$];
  exp_t dm_q[$];
  int   cyc = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  int          free_at, starve, resp_at;
  logic [31:0] resp_data;
  int          exp_if_wait, exp_dm_wait;
  bit          if_gnt_seen, dm_gnt_seen;
  int          mode;  // 0 random, 1 both always requesting with L=1, 2 drain
  int          win_log[$];
  int          win_cyc[$];
  int          exp_seq[6] = '{2, 2, 2, 2, 1, 2};

  // Response monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (bus.if_rvalid) begin
        if (if_q.size() == 0) check_bit("if_rvalid_unexpected", 1'b1, 1'b0);
        else begin
          e = if_q.pop_front();
          check("if_rdata", bus.if_rdata, e.data);
          check("if_rvalid_cycle", cyc, e.due);
        end
      end else check("if_rdata_idle", bus.if_rdata, 32'h0);
      if (bus.dm_rvalid) begin
        if (dm_q.size() == 0) check_bit("dm_rvalid_unexpected", 1'b1, 1'b0);
        else begin
          e = dm_q.pop_front();
          check("dm_rdata", bus.dm_rdata, e.data);
          check("dm_rvalid_cycle", cyc, e.due);
        end
      end else check("dm_rdata_idle", bus.dm_rdata, 32'h0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_wstrb = 4'h0;
    bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  task automatic at_drive();
    @(posedge clk); #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  // One clock of randomized traffic plus reference-model checking.
  task automatic run_cycle();
    int win;
    int lat;
    at_drive();
    cyc++;
    bus.mem_rvalid = (cyc == resp_at);
    bus.mem_rdata  = (cyc == resp_at) ? resp_data : $urandom();

    if (bus.if_req && !if_gnt_seen) begin
      if (mode == 0 && $urandom_range(0, 15) == 0) bus.if_req = 1'b0;
    end else if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
      bus.if_req  = 1'b1;
      bus.if_addr = $urandom();
    end else bus.if_req = 1'b0;

    if (bus.dm_req && !dm_gnt_seen) begin
      if (mode == 0 && $urandom_range(0, 15) == 0) bus.dm_req = 1'b0;
    end else if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.dm_wstrb = 4'($urandom_range(0, 15));
      bus.dm_addr  = $urandom();
      bus.dm_wdata = $urandom();
    end else bus.dm_req = 1'b0;

    at_sample();
    win = 0;
    if (cyc >= free_at) begin
      if (bus.if_req && (!bus.dm_req || starve == STARVE_MAX)) win = 1;
      else if (bus.dm_req) win = 2;
    end
    lat = (mode == 1) ? 1 : int'($urandom_range(1, 4));

    check("n_if_wait", n_if_wait, exp_if_wait);
    check("n_dm_wait", n_dm_wait, exp_dm_wait);
    check_bit("if_gnt", bus.if_gnt, win == 1);
    check_bit("dm_gnt", bus.dm_gnt, win == 2);
    check_bit("mem_req", bus.mem_req, win != 0);
    if (win == 1) begin
      check("if_mem_addr", bus.mem_addr, bus.if_addr);
      check_bit("if_mem_we", bus.mem_we, 1'b0);
      check("if_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
      check("if_mem_wdata", bus.mem_wdata, 32'h0);
      if_q.push_back('{data: mem_data(bus.if_addr), due: cyc + lat + 1});
      starve = 0;
    end else if (win == 2) begin
      check("dm_mem_addr", bus.mem_addr, bus.dm_addr);
      check_bit("dm_mem_we", bus.mem_we, bus.dm_we);
      check("dm_mem_wstrb", 32'(bus.mem_wstrb), 32'(bus.dm_wstrb));
      check("dm_mem_wdata", bus.mem_wdata, bus.dm_wdata);
      dm_q.push_back('{data: bus.dm_we ? 32'h0 : mem_data(bus.dm_addr), due: cyc + lat + 1});
      starve = bus.if_req ? starve + 1 : 0;
    end
    if (win != 0) free_at = cyc + lat + 1;

    // Memory: answer whatever the arbiter actually issued.
    if (bus.mem_req) begin
      resp_at   = cyc + lat;
      resp_data = mem_data(bus.mem_addr);
    end

    if (bus.if_gnt) begin win_log.push_back(1); win_cyc.push_back(cyc); end
    else if (bus.dm_gnt) begin win_log.push_back(2); win_cyc.push_back(cyc); end

    if (bus.if_req && win != 1) exp_if_wait++;
    if (bus.dm_req && win != 2) exp_dm_wait++;
    if_gnt_seen = bus.if_gnt;
    dm_gnt_seen = bus.dm_gnt;
  endtask

  initial begin
    idle_inputs();
    // Reset state, with both requests high: grants must stay low under reset.
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("rst_if_gnt", bus.if_gnt, 1'b0);
    check_bit("rst_dm_gnt", bus.dm_gnt, 1'b0);
    check_bit("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_n_if_wait", n_if_wait, 32'h0);
    check("rst_n_dm_wait", n_dm_wait, 32'h0);
    check_bit("rst_err", err, 1'b0);
    idle_inputs();
    n_rst = 1'b1;

    // Lone IF read, L = 2
    at_drive(); bus.if_req = 1'b1; bus.if_addr = 32'h100;
    at_sample();
    check_bit("lone_if_gnt", bus.if_gnt, 1'b1);
    check_bit("lone_mem_req", bus.mem_req, 1'b1);
    check("lone_mem_addr", bus.mem_addr, 32'h100);
    check_bit("lone_mem_we", bus.mem_we, 1'b0);
    check_bit("lone_dm_gnt", bus.dm_gnt, 1'b0);
    at_drive(); bus.if_req = 1'b0;
    at_sample(); check_bit("lone_busy_mem_req", bus.mem_req, 1'b0);
    at_drive(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    at_sample(); check_bit("lone_rvalid_early", bus.if_rvalid, 1'b0);
    at_drive(); bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    at_sample();
    check_bit("lone_if_rvalid", bus.if_rvalid, 1'b1);
    check("lone_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    check_bit("lone_dm_rvalid", bus.dm_rvalid, 1'b0);

    // Store, L = 1, issued from IDLE
    at_drive();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_wstrb = 4'h3;
    bus.dm_addr = 32'h200; bus.dm_wdata = 32'h1234;
    at_sample();
    check_bit("lone_if_rvalid_end", bus.if_rvalid, 1'b0);
    check("lone_if_rdata_end", bus.if_rdata, 32'h0);
    check_bit("st_dm_gnt", bus.dm_gnt, 1'b1);
    check_bit("st_mem_we", bus.mem_we, 1'b1);
    check("st_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
    check("st_mem_addr", bus.mem_addr, 32'h200);
    check("st_mem_wdata", bus.mem_wdata, 32'h1234);
    at_drive(); bus.dm_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    at_sample(); check_bit("st_rvalid_early", bus.dm_rvalid, 1'b0);
    at_drive(); bus.mem_rvalid = 1'b0;
    at_sample();
    check_bit("st_dm_rvalid", bus.dm_rvalid, 1'b1);
    check("st_dm_rdata", bus.dm_rdata, 32'h0);
    check_bit("st_err", err, 1'b0);
    check("st_n_if_wait", n_if_wait, 32'h0);

    // Reset while BUSY, with DM waiting so something observable is nonzero
    at_drive(); bus.if_req = 1'b1; bus.if_addr = 32'h300;
    at_sample(); check_bit("rb_if_gnt", bus.if_gnt, 1'b1);
    at_drive(); bus.if_req = 1'b0; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
    at_sample(); check_bit("rb_dm_gnt_busy", bus.dm_gnt, 1'b0);
    @(posedge clk); #1;
    check("rb_dm_wait_pre", n_dm_wait, 32'h1);
    #1 n_rst = 1'b0;
    #1;
    check("rb_n_dm_wait", n_dm_wait, 32'h0);
    check_bit("rb_dm_gnt", bus.dm_gnt, 1'b0);
    check_bit("rb_mem_req", bus.mem_req, 1'b0);
    check_bit("rb_if_rvalid", bus.if_rvalid, 1'b0);
    at_sample(); bus.dm_req = 1'b0; n_rst = 1'b1;
    at_drive(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_CAFE;
    at_sample(); check_bit("rb_err_before", err, 1'b0);
    at_drive(); bus.mem_rvalid = 1'b0;
    at_sample();
    check_bit("rb_err_late", err, 1'b1);
    check_bit("rb_no_if_rvalid", bus.if_rvalid, 1'b0);
    check_bit("rb_no_dm_rvalid", bus.dm_rvalid, 1'b0);

    // Spurious response in IDLE after reset
    n_rst = 1'b0;
    at_sample(); check_bit("sp_err_cleared", err, 1'b0);
    n_rst = 1'b1;
    at_drive(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    at_drive(); bus.mem_rvalid = 1'b0;
    at_sample();
    check_bit("sp_err", err, 1'b1);
    check_bit("sp_no_if_rvalid", bus.if_rvalid, 1'b0);
    check_bit("sp_no_dm_rvalid", bus.dm_rvalid, 1'b0);
    repeat (3) at_drive();
    at_sample(); check_bit("sp_err_held", err, 1'b1);
    at_drive(); bus.if_req = 1'b1; bus.if_addr = 32'h500;
    at_sample(); check_bit("sp_if_gnt", bus.if_gnt, 1'b1);
    at_drive(); bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = mem_data(32'h500);
    at_drive(); bus.mem_rvalid = 1'b0;
    at_sample();
    check_bit("sp_if_rvalid", bus.if_rvalid, 1'b1);
    check("sp_if_rdata", bus.if_rdata, mem_data(32'h500));
    check_bit("sp_err_still", err, 1'b1);

    // Model-checked traffic
    n_rst = 1'b0; idle_inputs();
    at_sample(); at_sample();
    n_rst = 1'b1;
    cyc = 0; free_at = 0; starve = 0; resp_at = -1; resp_data = 32'h0;
    exp_if_wait = 0; exp_dm_wait = 0; if_gnt_seen = 1'b0; dm_gnt_seen = 1'b0;
    win_log.delete(); win_cyc.delete();
    mon_en = 1'b1;

    mode = 1;
    repeat (30) run_cycle();
    check("conflict_grant_count", 32'(win_log.size()), 32'd15);
    for (int i = 0; i < 6; i++) check($sformatf("conflict_grant_%0d", i), win_log[i], exp_seq[i]);
    for (int i = 1; i < 10; i++) check($sformatf("conflict_spacing_%0d", i), win_cyc[i] - win_cyc[i-1], 32'd2);

    mode = 0;
    repeat (3000) run_cycle();
    mode = 2;
    repeat (30) run_cycle();
    mon_en = 1'b0;
    check("if_q_drained", 32'(if_q.size()), 32'h0);
    check("dm_q_drained", 32'(dm_q.size()), 32'h0);

    // Counter saturation: keep DM waiting behind a slow IF read
    idle_inputs();
    at_drive(); bus.if_req = 1'b1; bus.if_addr = 32'h600;
    at_sample(); check_bit("sat_if_gnt", bus.if_gnt, 1'b1);
    at_drive(); bus.if_req = 1'b0; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h700;
    at_sample();
    force dut.dm_wait_q = 32'hFFFF_FFFE;
    #1 release dut.dm_wait_q;
    for (int i = 0; i < 3; i++) begin
      at_sample();
      check($sformatf("sat_n_dm_wait_%0d", i), n_dm_wait, 32'hFFFF_FFFF);
      check_bit($sformatf("sat_dm_gnt_%0d", i), bus.dm_gnt, 1'b0);
    end
    at_drive(); bus.dm_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = mem_data(32'h600);
    at_drive(); bus.mem_rvalid = 1'b0;
    at_sample();
    check_bit("sat_if_rvalid", bus.if_rvalid, 1'b1);
    check("sat_if_rdata", bus.if_rdata, mem_data(32'h600));
    check("sat_n_dm_wait_end", n_dm_wait, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
